ssd_scan_driver: RTL
====================

# ssd_scan_driver

Parametrised multiplexed seven-segment display driver: scans NUM_DIGITS common-anode digits, one digit per time slot, with per-digit hex/raw-glyph selection, decimal points, blinking, leading-zero blanking, inter-digit dead time and PWM brightness. Frame contents are double-buffered behind a Load strobe so a new frame commits only at scan start (no tearing). Sits between application FSMs (lock, timer, counters) and the board ANODE/CATHODE pins, replacing the fixed four-digit, fixed-message display.

## Interface
- NUM_DIGITS, 4: digits scanned; digit 0 = rightmost.
- SCAN_DIV, 200000: Clock cycles per digit slot (500 Hz slot rate at 100 MHz).
- DEAD, 2000: cycles at slot start with all anodes off (anti-ghosting); DEAD < SCAN_DIV.
- BLINK_DIV, 64: full scans per blink half-period.
- Clock  in  1  system clock, all logic on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Load  in  1  capture Digits/Glyphs/Mode/Dp/Blink/Lzb into the pending buffer.
- Digits  in  4*NUM_DIGITS  hex nibble per digit.
- Glyphs  in  8*NUM_DIGITS  raw active-low {dp,a,b,c,d,e,f,g} per digit.
- Mode  in  NUM_DIGITS  1 = show Glyphs byte, 0 = decode Digits nibble.
- Dp  in  NUM_DIGITS  1 = light decimal point (hex mode only).
- Blink  in  NUM_DIGITS  1 = digit blinks.
- Lzb  in  1  enable leading-zero blanking.
- Brightness  in  4  0 = dark, 15 = full, else duty Brightness/16.
- ANODE  out  NUM_DIGITS  active-low digit enables.
- CATHODE  out  8  active-low {dp,a..g}.
- Scan_Tick  out  1  one-cycle pulse at each scan start.

## Operation
- Slot counter 0..SCAN_DIV-1; on wrap, digit index advances, N-1 wraps to 0.
- Anode for current index asserted only when slot_cnt >= DEAD and PWM gate true; otherwise ANODE all ones.
- PWM: free-running 4-bit counter, gate = (pwm_cnt < Brightness) or Brightness == 15.
- Blink: blink counter increments per Scan_Tick, toggles blink_phase at BLINK_DIV-1; Blink digits forced dark (CATHODE 8'hFF, anode off) while blink_phase = 1.
- Glyph: Mode=1 -> Glyphs byte verbatim; Mode=0 -> hex decode, dp bit = ~Dp.
- LZB (evaluated at Load): when Lzb=1, scanning from digit N-1 downward, hex-mode digits with value 0 are blanked until the first non-zero or raw-mode digit; digit 0 never blanked.
- Load: pending buffer captured each cycle Load=1; pending flag set. Multiple Loads before commit: last wins.
- Commit: on index wrap to 0 with pending=1, active buffer <- pending, flag cleared, same cycle as Scan_Tick.
- Load in the commit cycle: pending gets new data, flag stays set, old pending committed.
- Reset: active buffer = all digits dash (8'b11111110), pending clear, counters/index/blink_phase 0, ANODE all ones, CATHODE 8'hFF, Scan_Tick 0.
- Reset mid-scan: immediate return to reset state, no partial frame retained.

## Timing
- ANODE, CATHODE, Scan_Tick registered; one-cycle latency from counter state.
- CATHODE updates at slot start, during dead time, so segment change never coincides with an enabled anode.
- Frame latency: Load to visible <= NUM_DIGITS*SCAN_DIV + 1 cycles.
- Scan period NUM_DIGITS*SCAN_DIV; blink period 2*BLINK_DIV scans.
- Brightness sampled live (not buffered); takes effect next cycle.

## Structure
- Package ssd_pkg: glyph constants (DASH, OFF, letters L,O,C,k,P,A,S,F,I), hex-to-segment function, active-low encoding note.
- Sub-module ssd_hex_decode: combinational nibble+dp -> 8-bit glyph, instanced once on the selected digit.
- Top holds counters, PWM, blink, buffers, LZB mask, output registers.

## Test plan
(NUM_DIGITS=4, SCAN_DIV=8, DEAD=1, BLINK_DIV=2, Brightness=15)
- Reset release, no Load -> ANODE cycles 1110,1101,1011,0111 per 8-cycle slot, anode off first cycle of slot, CATHODE=8'b11111110 all digits.
- Load Digits=16'h1234, Mode=0 mid-scan -> old dashes until next Scan_Tick, then digit0=8'b11001100 ("4"), digit3=8'b11001111 ("1").
- Lzb=1, Digits=16'h0070 -> digits 3,2 dark (ANODE kept high), digit1 shows "7", digit0 shows "0".
- Blink=4'b0001 -> digit0 dark for 2 scans, lit for 2 scans, others always lit.
- Brightness=4, observe 16-cycle window -> anode low in at most 4 of 16 cycles; Brightness=0 -> ANODE stays 4'b1111.
- Two Loads (A then B) before wrap, Resetn pulse mid-slot -> B committed at wrap; after reset outputs 4'b1111/8'hFF, dashes displayed.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared glyph constants and hex decode; segments are active-low {dp,a,b,c,d,e,f,g}, 0 = lit
package ssd_pkg;

    localparam logic [7:0] SEG_DASH = 8'hFE;
    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_L    = 8'hF1;
    localparam logic [7:0] SEG_O    = 8'h81;
    localparam logic [7:0] SEG_C    = 8'hB1;
    localparam logic [7:0] SEG_K    = 8'hC8;
    localparam logic [7:0] SEG_P    = 8'h98;
    localparam logic [7:0] SEG_A    = 8'h88;
    localparam logic [7:0] SEG_S    = 8'hA4;
    localparam logic [7:0] SEG_F    = 8'hB8;
    localparam logic [7:0] SEG_I    = 8'hF9;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// ssd_hex_decode: nibble plus decimal-point request to active-low glyph
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] glyph
);

    assign glyph = {~dp, hex_seg(nibble)};

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed seven-segment scanner with double-buffered frames, blink, LZB, dead time and PWM
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 200000,
    parameter int DEAD       = 2000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Digits,
    input  logic [8*NUM_DIGITS-1:0] Glyphs,
    input  logic [NUM_DIGITS-1:0]   Mode,
    input  logic [NUM_DIGITS-1:0]   Dp,
    input  logic [NUM_DIGITS-1:0]   Blink,
    input  logic                    Lzb,
    input  logic [3:0]              Brightness,
    output logic [NUM_DIGITS-1:0]   ANODE,
    output logic [7:0]              CATHODE,
    output logic                    Scan_Tick
);

    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0]           slot_cnt;
    logic [IW-1:0]           idx;
    logic [3:0]              pwm_cnt;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] pend_dig, act_dig;
    logic [8*NUM_DIGITS-1:0] pend_gly, act_gly;
    logic [NUM_DIGITS-1:0]   pend_mode, act_mode;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   pend_blink, act_blink;
    logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
    logic                    pending;
    logic [NUM_DIGITS-1:0]   lzb_mask;
    logic                    leading;
    logic                    slot_wrap, scan_start, blink_last, dark, gate;
    logic [7:0]              dec_glyph, glyph_nx;
    logic [NUM_DIGITS-1:0]   anode_nx;

    assign slot_wrap  = slot_cnt == SW'(SCAN_DIV - 1);
    assign scan_start = slot_wrap && idx == IW'(NUM_DIGITS - 1);
    assign blink_last = blink_cnt == BW'(BLINK_DIV - 1);

    // blanking mask for the incoming frame: leading hex zeros from the left, digit 0 always kept
    always_comb begin
        lzb_mask = '0;
        leading  = Lzb;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (leading && !Mode[i] && Digits[4*i +: 4] == 4'h0) lzb_mask[i] = 1'b1;
            else leading = 1'b0;
        end
    end

    // slot/digit scan position, free-running PWM phase and blink phase
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            slot_cnt    <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            pwm_cnt  <= pwm_cnt + 1'b1;
            if (slot_wrap) idx <= scan_start ? '0 : idx + 1'b1;
            if (scan_start) begin
                blink_cnt   <= blink_last ? '0 : blink_cnt + 1'b1;
                blink_phase <= blink_phase ^ blink_last;
            end
        end
    end

    // pending frame captured on every Load; moved to the active frame only at scan start
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pend_dig   <= '0;
            pend_gly   <= '0;
            pend_mode  <= '0;
            pend_dp    <= '0;
            pend_blink <= '0;
            pend_blank <= '0;
            pending    <= 1'b0;
            act_dig    <= '0;
            act_gly    <= {NUM_DIGITS{SEG_DASH}};
            act_mode   <= '1;
            act_dp     <= '0;
            act_blink  <= '0;
            act_blank  <= '0;
        end else begin
            if (Load) begin
                pend_dig   <= Digits;
                pend_gly   <= Glyphs;
                pend_mode  <= Mode;
                pend_dp    <= Dp;
                pend_blink <= Blink;
                pend_blank <= lzb_mask;
            end
            pending <= Load | (pending & ~scan_start);
            if (scan_start && pending) begin
                act_dig   <= pend_dig;
                act_gly   <= pend_gly;
                act_mode  <= pend_mode;
                act_dp    <= pend_dp;
                act_blink <= pend_blink;
                act_blank <= pend_blank;
            end
        end
    end

    ssd_hex_decode u_dec (
        .nibble (act_dig[idx*4 +: 4]),
        .dp     (act_dp[idx]),
        .glyph  (dec_glyph)
    );

    // next segment/anode values for the digit currently being scanned
    always_comb begin
        dark     = act_blank[idx] | (act_blink[idx] & blink_phase);
        gate     = pwm_cnt < Brightness || Brightness == 4'hF;
        glyph_nx = dark ? SEG_OFF : act_mode[idx] ? act_gly[idx*8 +: 8] : dec_glyph;
        anode_nx = (!dark && slot_cnt >= SW'(DEAD) && gate) ? ~(NUM_DIGITS'(1) << idx) : '1;
    end

    // registered pin drivers; segments change while the anode is still in dead time
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ANODE     <= '1;
            CATHODE   <= SEG_OFF;
            Scan_Tick <= 1'b0;
        end else begin
            ANODE     <= anode_nx;
            CATHODE   <= glyph_nx;
            Scan_Tick <= scan_start;
        end
    end

endmodule
